// File: rtl/mux2_4_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter around mux2_4:
// FSM state encodings, mux select encodings and a small state-to-side helper.
package mux2_4_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GA   = 2'd1,
        ST_GB   = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Which side a grant state belongs to; IDLE maps to A, which matches sel's idle value.
    function automatic logic side_of(input state_e st);
        logic side;
        if (st == ST_GB) begin
            side = SEL_B;
        end else begin
            side = SEL_A;
        end
        return side;
    endfunction

endpackage

// File: rtl/mux2_4.sv
// Existing 4-bit 2:1 multiplexer: Out follows A when s is 0, otherwise B.
module mux2_4 (
    output logic [3:0] Out,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       s
);

    // Plain select; no storage.
    always_comb begin
        if (s == 1'b0) begin
            Out = A;
        end else begin
            Out = B;
        end
    end

endmodule

// File: rtl/mux2_4_rr_arbiter.sv
// Round-robin arbiter that owns the mux2_4 select and hands the shared mux to
// requester A or B, presenting the selected word through a valid/ready handshake.
module mux2_4_rr_arbiter
    import mux2_4_rr_arbiter_pkg::*;
#(
    parameter int W        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_a,
    input  logic [W-1:0] a,
    input  logic         req_b,
    input  logic [W-1:0] b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out
);

    localparam int                CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0]  HOLD_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HOLD_ZERO = CNT_W'(0);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0] hold_cnt_nxt_s;
    logic             last_r;
    logic             last_nxt_s;
    logic             gnt_a_r;
    logic             gnt_b_r;
    logic             sel_r;
    logic             gnt_a_nxt_s;
    logic             gnt_b_nxt_s;
    logic             sel_nxt_s;
    logic             valid_s;
    logic             xfer_s;
    logic             hold_full_s;

    assign valid_s     = (gnt_a_r & req_a) | (gnt_b_r & req_b);
    assign xfer_s      = valid_s & out_ready;
    assign hold_full_s = (hold_cnt_r == HOLD_LAST);

    // State, counter, last-owner and grant/select registers; reset drops any grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= HOLD_ZERO;
            last_r     <= SEL_B;
            gnt_a_r    <= 1'b0;
            gnt_b_r    <= 1'b0;
            sel_r      <= SEL_A;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            last_r     <= last_nxt_s;
            gnt_a_r    <= gnt_a_nxt_s;
            gnt_b_r    <= gnt_b_nxt_s;
            sel_r      <= sel_nxt_s;
        end
    end

    // Next-state: owner keeps the mux until it drops req or exhausts its hold budget with a waiter.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    if (last_r == SEL_A) begin
                        state_nxt_s = ST_GB;
                    end else begin
                        state_nxt_s = ST_GA;
                    end
                end else if (req_a) begin
                    state_nxt_s = ST_GA;
                end else if (req_b) begin
                    state_nxt_s = ST_GB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GA: begin
                if (!req_a) begin
                    state_nxt_s = req_b ? ST_GB : ST_IDLE;
                end else if (xfer_s && hold_full_s && req_b) begin
                    state_nxt_s = ST_GB;
                end else begin
                    state_nxt_s = ST_GA;
                end
            end
            ST_GB: begin
                if (!req_b) begin
                    state_nxt_s = req_a ? ST_GA : ST_IDLE;
                end else if (xfer_s && hold_full_s && req_a) begin
                    state_nxt_s = ST_GA;
                end else begin
                    state_nxt_s = ST_GB;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Hold counter counts accepted words per grant; a stall freezes it, a lone owner wraps it.
    always_comb begin
        hold_cnt_nxt_s = hold_cnt_r;
        if (state_nxt_s != state_r) begin
            hold_cnt_nxt_s = HOLD_ZERO;
        end else if (xfer_s) begin
            if (hold_full_s) begin
                hold_cnt_nxt_s = HOLD_ZERO;
            end else begin
                hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
            end
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end
    end

    // Remember the side being left so the next idle tie goes the other way.
    always_comb begin
        last_nxt_s = last_r;
        if ((state_r != ST_IDLE) && (state_nxt_s != state_r)) begin
            last_nxt_s = side_of(state_r);
        end else begin
            last_nxt_s = last_r;
        end
    end

    // Grant and select decoded from the next state so they register together with it.
    always_comb begin
        gnt_a_nxt_s = 1'b0;
        gnt_b_nxt_s = 1'b0;
        sel_nxt_s   = SEL_A;
        case (state_nxt_s)
            ST_GA: begin
                gnt_a_nxt_s = 1'b1;
                sel_nxt_s   = SEL_A;
            end
            ST_GB: begin
                gnt_b_nxt_s = 1'b1;
                sel_nxt_s   = SEL_B;
            end
            default: begin
                gnt_a_nxt_s = 1'b0;
                gnt_b_nxt_s = 1'b0;
                sel_nxt_s   = SEL_A;
            end
        endcase
    end

    mux2_4 u_mux (
        .Out (out),
        .A   (a),
        .B   (b),
        .s   (sel_r)
    );

    assign gnt_a     = gnt_a_r;
    assign gnt_b     = gnt_b_r;
    assign sel       = sel_r;
    assign out_valid = valid_s;

endmodule

// File: tb/tb_mux2_4_rr_arbiter.sv
// Directed bench for mux2_4_rr_arbiter: reset, tie-break, forced rotation,
// stall freeze, owner drop and reset during a grant, all with hand-computed expectations.
module tb_mux2_4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic [3:0] a;
    logic       req_b;
    logic [3:0] b;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out;

    int n_checks;
    int n_errors;

    mux2_4_rr_arbiter #(.W(4), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .a         (a),
        .req_b     (req_b),
        .b         (b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_a     = 1'b1;
        req_b     = 1'b1;
        a         = 4'h3;
        b         = 4'hC;
        out_ready = 1'b1;

        // Reset held two cycles with both requests up.
        cyc();
        cyc();
        chk("rst_gnt_a", {7'd0, gnt_a}, 8'd0);
        chk("rst_gnt_b", {7'd0, gnt_b}, 8'd0);
        chk("rst_sel", {7'd0, sel}, 8'd0);
        chk("rst_valid", {7'd0, out_valid}, 8'd0);

        // Release: tie goes to A first, then four words each side, then back to A.
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 9; i++) begin
            logic exp_b;
            exp_b = ((i / 4) % 2) == 1;
            chk($sformatf("rot_sel_%0d", i), {7'd0, sel}, {7'd0, exp_b});
            chk($sformatf("rot_gnt_a_%0d", i), {7'd0, gnt_a}, {7'd0, ~exp_b});
            chk($sformatf("rot_out_%0d", i), {4'd0, out}, exp_b ? 8'h0C : 8'h03);
            chk($sformatf("rot_valid_%0d", i), {7'd0, out_valid}, 8'd1);
            if (i < 8) begin
                cyc();
            end
        end

        // One accepted word on A, then a six-cycle stall must not use up the hold budget.
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall_gnt_a_%0d", i), {7'd0, gnt_a}, 8'd1);
            chk($sformatf("stall_valid_%0d", i), {7'd0, out_valid}, 8'd1);
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("resume_gnt_a_%0d", i), {7'd0, gnt_a}, 8'd1);
            cyc();
        end
        chk("resume_gnt_b", {7'd0, gnt_b}, 8'd1);
        chk("resume_sel", {7'd0, sel}, 8'd1);

        // A alone: grant moves to A and stays for ten cycles.
        req_b = 1'b0;
        a     = 4'hA;
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("solo_gnt_a_%0d", i), {7'd0, gnt_a}, 8'd1);
            chk($sformatf("solo_gnt_b_%0d", i), {7'd0, gnt_b}, 8'd0);
            chk($sformatf("solo_out_%0d", i), {4'd0, out}, 8'h0A);
            cyc();
        end

        // Go idle, A takes the mux, transfers once, drops; B takes over on the next edge.
        req_a = 1'b0;
        cyc();
        chk("idle_gnt_a", {7'd0, gnt_a}, 8'd0);
        chk("idle_valid", {7'd0, out_valid}, 8'd0);
        req_a = 1'b1;
        cyc();
        req_b = 1'b1;
        b     = 4'h5;
        chk("drop_gnt_a", {7'd0, gnt_a}, 8'd1);
        cyc();
        chk("drop_still_a", {7'd0, gnt_a}, 8'd1);
        req_a = 1'b0;
        #1;
        chk("drop_valid_low", {7'd0, out_valid}, 8'd0);
        cyc();
        chk("drop_gnt_b", {7'd0, gnt_b}, 8'd1);
        chk("drop_sel", {7'd0, sel}, 8'd1);
        chk("drop_out", {4'd0, out}, 8'h05);
        chk("drop_valid", {7'd0, out_valid}, 8'd1);

        // Reset while B owns the mux with a transfer pending; afterwards a tie goes to A.
        req_a = 1'b1;
        rst_n = 1'b0;
        cyc();
        chk("mrst_gnt_b", {7'd0, gnt_b}, 8'd0);
        chk("mrst_gnt_a", {7'd0, gnt_a}, 8'd0);
        chk("mrst_sel", {7'd0, sel}, 8'd0);
        chk("mrst_valid", {7'd0, out_valid}, 8'd0);
        rst_n = 1'b1;
        cyc();
        chk("mrst_tie_a", {7'd0, gnt_a}, 8'd1);

        // Leaving A then tying from idle must favour B.
        req_a = 1'b0;
        req_b = 1'b0;
        cyc();
        chk("tie2_idle", {7'd0, gnt_a | gnt_b}, 8'd0);
        req_a = 1'b1;
        req_b = 1'b1;
        cyc();
        chk("tie2_gnt_b", {7'd0, gnt_b}, 8'd1);
        chk("tie2_out", {4'd0, out}, 8'h05);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
